// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states and default memory timeout.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
    // Wide enough for the largest legal MEM_TIMEOUT (255).
    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller: memory-wait freezes, branch flush, hazard bubble,
// memory-timeout halt and a saturating stall performance counter.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_detected,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              perf_clr,
    output logic              freeze_front,
    output logic              freeze_mid,
    output logic              freeze_back,
    output logic              flush_IF_ID,
    output logic              bubble_ID_EXE,
    output logic              halted,
    output logic [PERF_W-1:0] stall_count
);

    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    state_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              any_ctl;

    assign mem_stall = mem_req & ~mem_ready;

    // wait_cnt holds the number of consecutive stalled cycles seen so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StRun;
            wait_cnt <= '0;
        end else begin
            case (state)
                StRun: begin
                    if (mem_stall) begin
                        state    <= StMemWait;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                StMemWait: begin
                    if (!mem_stall) begin
                        state <= StRun;
                    end else if (wait_cnt == TIMEOUT) begin
                        state <= StHalt;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state    <= StRun;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        freeze_front  = 1'b0;
        freeze_mid    = 1'b0;
        freeze_back   = 1'b0;
        flush_IF_ID   = 1'b0;
        bubble_ID_EXE = 1'b0;
        if ((state == StHalt) || mem_stall) begin
            freeze_front = 1'b1;
            freeze_mid   = 1'b1;
            freeze_back  = 1'b1;
        end else if (branch_taken) begin
            flush_IF_ID   = 1'b1;
            bubble_ID_EXE = 1'b1;
        end else if (hazard_detected) begin
            freeze_front  = 1'b1;
            bubble_ID_EXE = 1'b1;
        end
    end

    assign halted  = (state == StHalt);
    assign any_ctl = freeze_front | freeze_mid | freeze_back | flush_IF_ID | bubble_ID_EXE;

    sat_counter #(
        .W (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (any_ctl),
        .clr   (perf_clr),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench: table of control vectors, directed corner sequences and a
// randomized run against a cycle-level reference model.
module tb_pipeline_controller;

    localparam int unsigned TO     = 4;
    localparam int unsigned PERF_W = 16;
    localparam int          CMAX   = 65535;

    logic              clk = 1'b0;
    logic              rst;
    logic              hazard_detected;
    logic              branch_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              perf_clr;
    logic              freeze_front;
    logic              freeze_mid;
    logic              freeze_back;
    logic              flush_IF_ID;
    logic              bubble_ID_EXE;
    logic              halted;
    logic [PERF_W-1:0] stall_count;
    logic [4:0]        ctl;

    pipeline_controller #(
        .MEM_TIMEOUT (TO),
        .PERF_W      (PERF_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .perf_clr        (perf_clr),
        .freeze_front    (freeze_front),
        .freeze_mid      (freeze_mid),
        .freeze_back     (freeze_back),
        .flush_IF_ID     (flush_IF_ID),
        .bubble_ID_EXE   (bubble_ID_EXE),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    assign ctl = {freeze_front, freeze_mid, freeze_back, flush_IF_ID, bubble_ID_EXE};

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: halted flag, length of current stall run, stall cycle count.
    bit m_halted;
    int m_run;
    int m_cnt;

    typedef struct {
        logic       h;
        logic       b;
        logic       q;
        logic       r;
        logic [4:0] e;
    } vec_t;

    // Returns {freeze_front, freeze_mid, freeze_back, flush_IF_ID, bubble_ID_EXE}.
    function automatic logic [4:0] exp_ctl(input logic h, input logic b, input logic q,
                                           input logic r, input bit hlt);
        if (hlt || (q && !r)) return 5'b11100;
        if (b) return 5'b00011;
        if (h) return 5'b10001;
        return 5'b00000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic h, input logic b, input logic q, input logic r,
                         input logic c);
        hazard_detected = h;
        branch_taken    = b;
        mem_req         = q;
        mem_ready       = r;
        perf_clr        = c;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic h, input logic b, input logic q, input logic r,
                         input logic c);
        logic [4:0] e;
        drive(h, b, q, r, c);
        #3;
        e = exp_ctl(h, b, q, r, m_halted);
        check("ctl", 32'(ctl), 32'(e));
        check("halted", 32'(halted), 32'(m_halted));
        check("stall_count", 32'(stall_count), 32'(m_cnt));
        @(posedge clk);
        if (c) m_cnt = 0;
        else if (e != 5'b0 && m_cnt < CMAX) m_cnt++;
        if (!m_halted) begin
            if (q && !r) begin
                m_run++;
                if (m_run > int'(TO)) m_halted = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases after one edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        m_halted = 1'b0;
        m_run    = 0;
        m_cnt    = 0;
        #1;
        check("rst_ctl", 32'(ctl), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_count", 32'(stall_count), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{h: 1'b0, b: 1'b0, q: 1'b0, r: 1'b0, e: 5'b00000};
        tbl[1] = '{h: 1'b1, b: 1'b0, q: 1'b0, r: 1'b0, e: 5'b10001};
        tbl[2] = '{h: 1'b0, b: 1'b1, q: 1'b0, r: 1'b0, e: 5'b00011};
        tbl[3] = '{h: 1'b1, b: 1'b1, q: 1'b0, r: 1'b0, e: 5'b00011};
        tbl[4] = '{h: 1'b0, b: 1'b0, q: 1'b1, r: 1'b0, e: 5'b11100};
        tbl[5] = '{h: 1'b1, b: 1'b1, q: 1'b1, r: 1'b0, e: 5'b11100};
        tbl[6] = '{h: 1'b0, b: 1'b0, q: 1'b1, r: 1'b1, e: 5'b00000};
        tbl[7] = '{h: 1'b1, b: 1'b1, q: 1'b1, r: 1'b1, e: 5'b00011};
        tbl[8] = '{h: 1'b0, b: 1'b0, q: 1'b0, r: 1'b1, e: 5'b00000};
        tbl[9] = '{h: 1'b1, b: 1'b0, q: 1'b1, r: 1'b1, e: 5'b10001};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_halted = 1'b0;
        m_run    = 0;
        m_cnt    = 0;
        #2;
        check("init_ctl", 32'(ctl), 32'(0));
        check("init_halted", 32'(halted), 32'(0));
        check("init_count", 32'(stall_count), 32'(0));

        // Held in reset the FSM sits in RUN, so the table exercises the RUN decode.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].h, tbl[i].b, tbl[i].q, tbl[i].r, 1'b0);
            #1;
            check($sformatf("tbl%0d_ctl", i), 32'(ctl), 32'(tbl[i].e));
        end
        @(posedge clk);
        check("tbl_count_in_rst", 32'(stall_count), 32'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;

        // Single-cycle hazard bubble.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hazard_count", 32'(stall_count), 32'(1));

        // Three-cycle memory wait, then completion.
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("memwait_count", 32'(stall_count), 32'(3));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Memory timeout into HALT; inputs then ignored until reset.
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_halt", 32'(halted), 32'(0));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("halt_set", 32'(halted), 32'(1));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("halt_freeze", 32'(ctl), 32'(5'b11100));
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of MEM_WAIT.
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_ctl", 32'(ctl), 32'(0));

        // Counter saturation and clear priority.
        do_reset();
        repeat (65534) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("count_fffe", 32'(stall_count), 32'(16'hFFFE));
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("count_sat", 32'(stall_count), 32'(16'hFFFF));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("count_clr", 32'(stall_count), 32'(0));

        // Randomized run with varying memory-ready density.
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            int unsigned rdy_pct;
            rdy_pct = $urandom_range(0, 9);
            for (int k = 0; k < 50; k++) begin
                if ($urandom_range(0, 149) == 0) begin
                    #1;
                    do_reset();
                end
                cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < rdy_pct),
                      1'($urandom_range(0, 19) == 0));
            end
            if (m_halted) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, the number of consecutive memory-wait cycles before the pipeline halts (range 2..255).
REQ-002 Parameter: PERF_W, default 16, the width of the stall performance counter.
REQ-003 clk  input  1  pipeline clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 hazard_detected  input  1  load-use/RAW hazard flag from the hazard detection unit.
REQ-006 branch_taken  input  1  branch resolved taken in EXE this cycle.
REQ-007 mem_req  input  1  MEM stage holds a load or store this cycle.
REQ-008 mem_ready  input  1  data memory completes the access this cycle.
REQ-009 perf_clr  input  1  synchronous clear of stall_count.
REQ-010 freeze_front  output  1  hold the PC and the IF/ID register.
REQ-011 freeze_mid  output  1  hold the ID/EXE register.
REQ-012 freeze_back  output  1  hold the EXE/MEM and MEM/WB registers.
REQ-013 flush_IF_ID  output  1  load a NOP into IF/ID.
REQ-014 bubble_ID_EXE  output  1  load a NOP (all enables 0) into ID/EXE.
REQ-015 halted  output  1  sticky memory-timeout indication.
REQ-016 stall_count  output  PERF_W  saturating count of cycles in which any freeze, flush or bubble output is 1.

Function
REQ-017 mem_stall SHALL be mem_req AND NOT mem_ready.
REQ-018 FSM states SHALL be RUN, MEM_WAIT and HALT; control outputs SHALL be Mealy-combinational from the state and the current inputs.
REQ-019 In RUN or MEM_WAIT with mem_stall=1, freeze_front, freeze_mid and freeze_back SHALL be 1, flush_IF_ID and bubble_ID_EXE SHALL be 0, and branch_taken and hazard_detected SHALL be ignored.
REQ-020 Else, if branch_taken=1: flush_IF_ID=1, bubble_ID_EXE=1, all freezes 0, and hazard_detected ignored.
REQ-021 Else, if hazard_detected=1: freeze_front=1, bubble_ID_EXE=1, freeze_mid=0, freeze_back=0, flush_IF_ID=0.
REQ-022 Otherwise all five control outputs SHALL be 0.
REQ-023 Transition RUN->MEM_WAIT SHALL occur when mem_stall=1.
REQ-024 Transition MEM_WAIT->RUN SHALL occur when mem_stall=0, whether from mem_ready or from mem_req dropping; the outputs in that cycle follow REQ-020..022.
REQ-025 A wait counter SHALL be cleared on entry to MEM_WAIT (the first stalled cycle counts as 1) and SHALL increment each stalled cycle.
REQ-026 When the counter equals MEM_TIMEOUT and mem_stall is still 1, the FSM SHALL go to HALT at the next edge.
REQ-027 In HALT: all three freezes 1, flush_IF_ID and bubble_ID_EXE 0, halted 1, and all inputs ignored except rst.
REQ-028 stall_count SHALL increment by 1 per qualifying cycle and saturate at all-ones.
REQ-029 perf_clr SHALL set stall_count to 0 at the next edge and SHALL take priority over an increment in the same cycle.
REQ-030 In HALT, stall_count SHALL keep counting until it saturates.

Reset
REQ-031 rst SHALL force, asynchronously: state RUN, wait counter 0, stall_count 0, halted 0.
REQ-032 During reset, all control outputs SHALL be 0 unless mem_stall=1 (RUN-state rules apply).
REQ-033 Reset asserted mid-MEM_WAIT or in HALT SHALL return the FSM to RUN with no residual freeze.

Structure
REQ-034 The FSM state enum and the default MEM_TIMEOUT SHALL live in shared package pipeline_ctrl_pkg.
REQ-035 Register-address widths SHALL come from defines.v.
REQ-036 The saturating perf counter SHALL be one sub-module, sat_counter (parameter W; inputs inc and clr).

Verification
REQ-037 hazard_detected=1 for 1 cycle in RUN -> freeze_front=1, bubble_ID_EXE=1 that cycle only; stall_count goes 0->1.
REQ-038 branch_taken=1 with hazard_detected=1 -> flush_IF_ID=1, bubble_ID_EXE=1, freeze_front=0.
REQ-039 mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all freezes 1 for 3 cycles, state back in RUN after the 4th edge, stall_count=3.
REQ-040 MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> halted=1 from the 5th edge onward, freezes stay 1 after mem_ready=1, and clear only on rst.
REQ-041 stall_count preloaded to 16'hFFFE with continuous hazard_detected -> reaches 16'hFFFF and holds; perf_clr=1 -> 0 next edge.
REQ-042 rst asserted asynchronously mid-MEM_WAIT with mem_req=0 -> all outputs 0 immediately, and RUN with no freeze after release.
